// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-ported data memory.
interface dmem_arbiter_if;
  logic        req0, req1, we0, we1, uns0, uns1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  size0, size1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [1:0]  mem_size;

  modport slave (
    input  req0, req1, we0, we1, uns0, uns1, addr0, addr1, wdata0, wdata1, size0, size1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_we, mem_size
  );

  modport master (
    output req0, req1, we0, we1, uns0, uns1, addr0, addr1, wdata0, wdata1, size0, size1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_wdata, mem_we, mem_size
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one data memory between two ports,
// with a registered, size-extended load response per port.

module dmem_arbiter_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap,
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic        rvalid,
  output logic [31:0] rdata
);
  logic [31:0] word_q;
  logic [1:0]  size_q;
  logic        uns_q;

  // Captured fields hold between loads so rdata stays stable until the next response.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rvalid <= 1'b0;
      word_q <= '0;
      size_q <= 2'b10;
      uns_q  <= 1'b0;
    end else begin
      rvalid <= cap;
      if (cap) begin
        word_q <= word;
        size_q <= size;
        uns_q  <= uns;
      end
    end

  always_comb begin
    case (size_q)
      2'b00:   rdata = {{24{~uns_q & word_q[7]}},  word_q[7:0]};
      2'b01:   rdata = {{16{~uns_q & word_q[15]}}, word_q[15:0]};
      default: rdata = word_q;
    endcase
  end
endmodule

module dmem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int         NUM_PORTS = 2;
  localparam logic [3:0] MAXB      = 4'(MAX_BURST);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } req_t;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  logic [NUM_PORTS-1:0]       req, gnt, rvalid;
  logic [NUM_PORTS-1:0][31:0] rdata;
  req_t [NUM_PORTS-1:0]       rq;
  req_t                       sel;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       gv, gp;

  assign req   = {bus.req1, bus.req0};
  assign rq[0] = {bus.we0, bus.addr0, bus.wdata0, bus.size0, bus.uns0};
  assign rq[1] = {bus.we1, bus.addr1, bus.wdata1, bus.size1, bus.uns1};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end

  // Contention only moves off the owner once it has used its full burst.
  always_comb begin
    gv      = |req;
    gp      = 1'b0;
    state_n = IDLE;
    cnt_n   = '0;
    if (req == 2'b10)
      gp = 1'b1;
    else if (req == 2'b11)
      case (state)
        OWN0:    gp = (cnt >= MAXB);
        OWN1:    gp = (cnt <  MAXB);
        default: gp = 1'b0;
      endcase
    if (gv) begin
      state_n = gp ? OWN1 : OWN0;
      if (state_n == state) cnt_n = (cnt >= MAXB) ? MAXB : cnt + 4'd1;
      else                  cnt_n = 4'd1;
    end
  end

  always_comb begin
    sel           = rq[gp];
    gnt           = '0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_size  = 2'b10;
    if (gv) begin
      gnt[gp]       = 1'b1;
      bus.mem_we    = sel.we;
      bus.mem_addr  = sel.addr;
      bus.mem_wdata = sel.wdata;
      bus.mem_size  = (sel.size == 2'b11) ? 2'b10 : sel.size;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    dmem_arbiter_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .cap    (gnt[p] & ~rq[p].we),
      .word   (bus.mem_rdata),
      .size   (rq[p].size),
      .uns    (rq[p].uns),
      .rvalid (rvalid[p]),
      .rdata  (rdata[p])
    );
  end

  assign bus.gnt0    = gnt[0];
  assign bus.gnt1    = gnt[1];
  assign bus.rvalid0 = rvalid[0];
  assign bus.rvalid1 = rvalid[1];
  assign bus.rdata0  = rdata[0];
  assign bus.rdata1  = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized check of dmem_arbiter against a transaction-level model
// of the grant rules, a reference memory image and arithmetic load extension.
module tb_dmem_arbiter;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bif();
  dmem_arbiter #(.MAX_BURST(MB)) dut (.clk(clk), .rst(rst), .bus(bif));

  // Behavioural memory device: combinational read, write on the grant edge.
  logic [31:0] tbmem [32] = '{default: 32'h0};
  assign bif.mem_rdata = tbmem[bif.mem_addr[4:0]];
  always @(posedge clk)
    if (bif.mem_we)
      case (bif.mem_size)
        2'b00:   tbmem[bif.mem_addr[4:0]][7:0]  <= bif.mem_wdata[7:0];
        2'b01:   tbmem[bif.mem_addr[4:0]][15:0] <= bif.mem_wdata[15:0];
        default: tbmem[bif.mem_addr[4:0]]       <= bif.mem_wdata;
      endcase

  int checks = 0, failures = 0;
  int owner = -1, streak = 0, last_g = -1;
  logic        r_req [2], r_we [2], r_uns [2];
  logic [31:0] r_addr [2], r_wd [2];
  logic [1:0]  r_sz [2];
  logic        exp_rv [2];
  logic [31:0] exp_rd [2];
  logic [31:0] ref_mem [32];

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ext(logic [31:0] w, logic [1:0] sz, logic u);
    int unsigned v;
    if (sz == 2'd0) begin
      v = w % 256;
      if (!u && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = w % 65536;
      if (!u && v >= 32768) v = v + 32'hFFFF_0000;
    end else
      v = w;
    return v;
  endfunction

  function automatic int pick(logic r0, logic r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0) return -1;
    if (owner < 0) return 0;
    return (streak < MB) ? owner : 1 - owner;
  endfunction

  task automatic setp(int p, logic r, logic we, logic [31:0] a, logic [31:0] wd, logic [1:0] sz, logic u);
    r_req[p] = r; r_we[p] = we; r_addr[p] = a; r_wd[p] = wd; r_sz[p] = sz; r_uns[p] = u;
    bif.req0 = r_req[0]; bif.we0 = r_we[0]; bif.addr0 = r_addr[0];
    bif.wdata0 = r_wd[0]; bif.size0 = r_sz[0]; bif.uns0 = r_uns[0];
    bif.req1 = r_req[1]; bif.we1 = r_we[1]; bif.addr1 = r_addr[1];
    bif.wdata1 = r_wd[1]; bif.size1 = r_sz[1]; bif.uns1 = r_uns[1];
  endtask

  task automatic model_reset();
    owner = -1; streak = 0;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    exp_rd[0] = '0;   exp_rd[1] = '0;
  endtask

  // One clock cycle: check the current cycle against the model, then advance it.
  task automatic step();
    int g;
    logic [31:0] mask;
    #1;
    g = pick(r_req[0], r_req[1]);
    chk1("gnt0", bif.gnt0, g == 0);
    chk1("gnt1", bif.gnt1, g == 1);
    chk1("rvalid0", bif.rvalid0, exp_rv[0]);
    chk1("rvalid1", bif.rvalid1, exp_rv[1]);
    chk32("rdata0", bif.rdata0, exp_rd[0]);
    chk32("rdata1", bif.rdata1, exp_rd[1]);
    if (g >= 0) begin
      chk32("mem_addr", bif.mem_addr, r_addr[g]);
      chk1("mem_we", bif.mem_we, r_we[g]);
      chk32("mem_wdata", bif.mem_wdata, r_wd[g]);
      chk32("mem_size", 32'(bif.mem_size), (r_sz[g] == 2'd3) ? 32'd2 : 32'(r_sz[g]));
    end else begin
      chk32("idle_addr", bif.mem_addr, 32'd0);
      chk1("idle_we", bif.mem_we, 1'b0);
      chk32("idle_wdata", bif.mem_wdata, 32'd0);
      chk32("idle_size", 32'(bif.mem_size), 32'd2);
    end
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    if (g >= 0) begin
      if (r_we[g]) begin
        mask = (r_sz[g] == 2'd0) ? 32'd255 : (r_sz[g] == 2'd1) ? 32'd65535 : 32'hFFFF_FFFF;
        ref_mem[r_addr[g][4:0]] = (ref_mem[r_addr[g][4:0]] & ~mask) | (r_wd[g] & mask);
      end else begin
        exp_rv[g] = 1'b1;
        exp_rd[g] = ext(ref_mem[r_addr[g][4:0]], r_sz[g], r_uns[g]);
      end
      if (g == owner) streak = (streak >= MB) ? MB : streak + 1;
      else begin owner = g; streak = 1; end
    end else begin
      owner = -1; streak = 0;
    end
    last_g = g;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ext_tab [4];
    logic        seq [9];
    ext_tab = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_80F0};
    seq     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    model_reset();
    setp(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
    setp(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);

    // Reset state
    #12;
    chk1("rst_gnt0", bif.gnt0, 1'b0);
    chk1("rst_gnt1", bif.gnt1, 1'b0);
    chk1("rst_rvalid0", bif.rvalid0, 1'b0);
    chk1("rst_rvalid1", bif.rvalid1, 1'b0);
    chk32("rst_rdata0", bif.rdata0, 32'd0);
    chk32("rst_rdata1", bif.rdata1, 32'd0);
    chk32("rst_mem_size", 32'(bif.mem_size), 32'd2);
    rst = 1'b0;
    @(posedge clk); #1;

    // Store then load of the same address on port 0
    setp(0, 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 2'd2, 1'b0);
    step();
    chk1("st_no_rvalid0", bif.rvalid0, 1'b0);
    setp(0, 1'b1, 1'b0, 32'd5, 32'd0, 2'd2, 1'b0);
    step();
    chk1("ld_rvalid0", bif.rvalid0, 1'b1);
    chk1("ld_rvalid1", bif.rvalid1, 1'b0);
    chk32("ld_rdata0", bif.rdata0, 32'hDEAD_BEEF);

    // Byte/half extension, back-to-back loads
    setp(0, 1'b1, 1'b1, 32'd9, 32'h0000_80F0, 2'd2, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      setp(0, 1'b1, 1'b0, 32'd9, 32'd0, (k < 2) ? 2'd0 : 2'd1, 1'(k % 2));
      step();
      chk1("ext_rvalid0", bif.rvalid0, 1'b1);
      chk32("ext_rdata0", bif.rdata0, ext_tab[k]);
    end
    setp(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
    step();

    // Both ports requesting continuously from IDLE
    setp(0, 1'b1, 1'b0, 32'd5, 32'd0, 2'd2, 1'b0);
    setp(1, 1'b1, 1'b0, 32'd9, 32'd0, 2'd2, 1'b1);
    for (int i = 0; i < 9; i++) begin
      #1;
      chk1("burst_gnt1", bif.gnt1, seq[i]);
      chk1("burst_gnt0", bif.gnt0, ~seq[i]);
      step();
    end

    // Port 1 alone saturates, then port 0 joins and wins
    setp(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk1("solo_gnt1", bif.gnt1, 1'b1);
      step();
    end
    setp(0, 1'b1, 1'b0, 32'd5, 32'd0, 2'd2, 1'b0);
    #1;
    chk1("join_gnt0", bif.gnt0, 1'b1);
    chk1("join_gnt1", bif.gnt1, 1'b0);
    step();
    setp(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
    setp(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
    step();

    // Size 11 store writes a full word and gives no rvalid
    setp(0, 1'b1, 1'b1, 32'd20, 32'h1234_5678, 2'd3, 1'b0);
    #1;
    chk32("sz3_mem_size", 32'(bif.mem_size), 32'd2);
    step();
    chk1("sz3_rvalid0", bif.rvalid0, 1'b0);
    chk1("sz3_rvalid1", bif.rvalid1, 1'b0);
    setp(0, 1'b1, 1'b0, 32'd20, 32'd0, 2'd2, 1'b0);
    step();
    chk32("sz3_rdata0", bif.rdata0, 32'h1234_5678);
    setp(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
    step();

    // Reset pulse after a load grant drops the response and returns to IDLE
    setp(1, 1'b1, 1'b0, 32'd5, 32'd0, 2'd2, 1'b0);
    step();
    setp(1, 1'b1, 1'b0, 32'd9, 32'd0, 2'd2, 1'b0);
    #1;
    chk1("mid_gnt1", bif.gnt1, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk1("mid_rvalid1", bif.rvalid1, 1'b0);
    chk32("mid_rdata1", bif.rdata1, 32'd0);
    rst = 1'b0;
    model_reset();
    setp(0, 1'b1, 1'b0, 32'd5, 32'd0, 2'd2, 1'b0);
    #1;
    chk1("mid_idle_gnt0", bif.gnt0, 1'b1);
    step();
    setp(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
    setp(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
    step();
    step();

    // Random traffic; an ungranted request is held unchanged
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        if (!r_req[p] || last_g == p)
          setp(p, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)),
               32'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
